fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage and IF/ID pipeline register. It feeds the decode stage and consumes decode's next-PC selection in return.
- Owns the PC and issues requests to a multi-cycle instruction memory.
- Presents {instruction, PC_2, if_valid} to decode. Applies decode's redirect (PCSrc plus targets), stall and halt (fetch_enable=0).

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0800, instruction word driven when the IF/ID slot is invalid or squashed

Ports:
clk  input  1  clock, all state updates on the rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
imem_req  output  1  instruction-memory request, held until imem_ready
imem_addr  output  16  fetch address; equals PC and is stable while imem_req=1
imem_rdata  input  16  instruction word, valid in the cycle imem_ready=1
imem_ready  input  1  memory completion strobe
stall  input  1  decode or hazard unit holds IF/ID
PCSrc  input  3  next-PC select from decode: 000 seq, 001 PC_2_I, 010 PC_2_D, 011 reg_target, 1xx reserved
PC_2_I  input  16  branch target from decode
PC_2_D  input  16  jump target from decode
reg_target  input  16  register-indirect target (JR/JALR)
fetch_enable  input  1  0 means decode holds HALT; stop fetching
instruction  output  16  IF/ID instruction register
PC_2  output  16  IF/ID PC+2 of that instruction
if_valid  output  1  IF/ID slot holds a real instruction
halted  output  1  fetch permanently stopped
err  output  1  sticky; set on reserved PCSrc when a redirect is taken

Behaviour:
- Reset while rst=0, at any time including mid-request:
  - PC=RESET_PC, state=FETCH, instruction=NOP_INSTR, PC_2=0, if_valid=0, halted=0, err=0, imem_req=0.
  - imem_req rises in the first cycle after rst goes to 1.
- States:
  - FETCH: imem_req=1 with imem_addr=PC. When imem_ready=1, go to CAPTURE.
  - CAPTURE: the fetched word sits in an internal holding register until it can enter IF/ID.
  - SQUASH: a request is still in flight but its data is unwanted. Keep imem_req=1 until imem_ready=1, discard the data, then go to FETCH at the new PC.
  - HALTED: absorbing. imem_req=0, if_valid=0, halted=1. Only reset leaves it.
- IF/ID advance occurs when stall=0 and a captured word is available: the word is in CAPTURE, or imem_ready=1 in FETCH as a same-cycle bypass.
  - On advance: instruction<=word, PC_2<=PC+2 (mod 2^16, 16'hFFFE wraps to 16'h0000), if_valid<=1, PC<=PC+2, then FETCH.
  - With stall=0 and no word available: if_valid<=0 and instruction<=NOP_INSTR.
  - With stall=1: instruction, PC_2 and if_valid hold. A captured word waits in CAPTURE and the next request is not issued.
- Best-case throughput is 1 instruction/cycle when imem_ready is tied to 1. Latency from request to IF/ID is one cycle after imem_ready.
- Redirect condition: if_valid=1, stall=0, PCSrc!=000.
  - Target: 001→PC_2_I, 010→PC_2_D, 011→reg_target.
  - 1xx→ no redirect, PC continues sequentially, err<=1.
  - Effect: PC<=target, IF/ID<=NOP_INSTR with if_valid=0. Any word in CAPTURE is dropped.
  - If a request is in flight and not completing this cycle, go to SQUASH. If it completes this cycle, drop the data and go to FETCH at the target.
- Halt condition: if_valid=1 and fetch_enable=0, evaluated even when stall=1.
  - Enter HALTED next cycle. IF/ID holds the HALT instruction.
  - An in-flight request is abandoned: imem_req drops and its memory response is ignored.
- Priority, highest first: reset > halt > redirect > stall > sequential advance.
- imem_addr never changes while imem_req=1 and imem_ready=0.

Test Plan:
- Release reset with imem_ready tied to 1 and memory returning 16'h4001,16'h4002,16'h4003 at 0,2,4. Expect imem_addr 0→2→4. IF/ID shows 4001/PC_2=2, 4002/4, 4003/6 on consecutive cycles, with if_valid=0 only in the first cycle.
- Set imem_ready=1 only every 3rd cycle. Expect imem_addr to stay stable while waiting, if_valid=0 bubbles between words, and no word dropped or duplicated.
- With IF/ID holding PC_2=16'h0010, assert stall=1 for 4 cycles while memory completes the next fetch. Expect IF/ID unchanged and the fetch at 0x0010 held in CAPTURE. After stall drops, IF/ID gets 0x0010's word next cycle and PC becomes 0x0012.
- Drive PCSrc=001, PC_2_I=16'h0040 while a request is in flight with imem_ready low for 2 cycles. Expect if_valid=0 next cycle, SQUASH discarding the returned word, then imem_addr=0x0040. Repeat with PCSrc=100: expect err=1 sticky and sequential PC.
- Drive fetch_enable=0 with if_valid=1. Expect halted=1 and imem_req=0 the next cycle and indefinitely after. Then pulse rst=0 mid-halt: expect PC=0 and outputs at reset values immediately (asynchronous), with fetch resuming after release.
- Fetch at PC=16'hFFFE. Expect PC_2=16'h0000 and the next imem_addr=16'h0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a multi-cycle instruction memory
// and holds the IF/ID register consumed by decode.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic [2:0]  PCSrc,
    input  logic [15:0] PC_2_I,
    input  logic [15:0] PC_2_D,
    input  logic [15:0] reg_target,
    input  logic        fetch_enable,
    output logic [15:0] instruction,
    output logic [15:0] PC_2,
    output logic        if_valid,
    output logic        halted,
    output logic        err
);

    localparam logic [1:0] S_FETCH   = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_SQUASH  = 2'd2;
    localparam logic [1:0] S_HALTED  = 2'd3;

    logic [1:0]  state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [15:0] hold_word, hold_word_nxt;
    logic [15:0] sq_target, sq_target_nxt;
    logic [15:0] instr_nxt, pc_2_nxt;
    logic        valid_nxt, err_nxt;

    logic        fetch_done, word_avail, do_halt, src_taken, do_redirect;
    logic [15:0] word, pc_inc, target;

    function automatic logic [15:0] sel_target(input logic [1:0] sel,
                                               input logic [15:0] t_i,
                                               input logic [15:0] t_d,
                                               input logic [15:0] t_r);
        case (sel)
            2'b01:   return t_i;
            2'b10:   return t_d;
            default: return t_r;
        endcase
    endfunction

    // Request is live in FETCH and SQUASH; reset forces it low immediately.
    assign imem_req  = rst & ((state == S_FETCH) | (state == S_SQUASH));
    assign imem_addr = pc;
    assign halted    = (state == S_HALTED);

    assign fetch_done  = (state == S_FETCH) & imem_ready;
    assign word_avail  = (state == S_CAPTURE) | fetch_done;
    assign word        = (state == S_CAPTURE) ? hold_word : imem_rdata;
    assign pc_inc      = pc + 16'd2;
    assign do_halt     = if_valid & ~fetch_enable;
    assign src_taken   = if_valid & ~stall & (PCSrc != 3'b000);
    assign do_redirect = src_taken & ~PCSrc[2];
    assign target      = sel_target(PCSrc[1:0], PC_2_I, PC_2_D, reg_target);

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        hold_word_nxt = hold_word;
        sq_target_nxt = sq_target;
        instr_nxt     = instruction;
        pc_2_nxt      = PC_2;
        valid_nxt     = if_valid;
        err_nxt       = err;

        if (state == S_HALTED) begin
            valid_nxt = 1'b0;
        end else if (do_halt) begin
            // HALT stays visible in IF/ID; any in-flight response is abandoned.
            state_nxt = S_HALTED;
            valid_nxt = 1'b0;
        end else begin
            if (src_taken && PCSrc[2])
                err_nxt = 1'b1;

            if (do_redirect) begin
                instr_nxt = NOP_INSTR;
                valid_nxt = 1'b0;
                if (state == S_FETCH && !imem_ready) begin
                    state_nxt     = S_SQUASH;
                    sq_target_nxt = target;
                end else begin
                    state_nxt = S_FETCH;
                    pc_nxt    = target;
                end
            end else if (state == S_SQUASH) begin
                if (!stall) begin
                    instr_nxt = NOP_INSTR;
                    valid_nxt = 1'b0;
                end
                // imem_addr must stay on the old PC until the stale word returns.
                if (imem_ready) begin
                    state_nxt = S_FETCH;
                    pc_nxt    = sq_target;
                end
            end else if (stall) begin
                if (fetch_done) begin
                    state_nxt     = S_CAPTURE;
                    hold_word_nxt = imem_rdata;
                end
            end else if (word_avail) begin
                instr_nxt = word;
                pc_2_nxt  = pc_inc;
                valid_nxt = 1'b1;
                pc_nxt    = pc_inc;
                state_nxt = S_FETCH;
            end else begin
                instr_nxt = NOP_INSTR;
                valid_nxt = 1'b0;
            end
        end
    end

    // IF/ID boundary and control state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            instruction <= NOP_INSTR;
            PC_2        <= 16'h0000;
            if_valid    <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instruction <= instr_nxt;
            PC_2        <= pc_2_nxt;
            if_valid    <= valid_nxt;
            err         <= err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        hold_word <= hold_word_nxt;
        sq_target <= sq_target_nxt;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a flag-based behavioural model of
// the fetch stage and a synthetic instruction memory.
module tb_fetch_unit;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic [2:0]  PCSrc;
    logic [15:0] PC_2_I, PC_2_D, reg_target;
    logic        fetch_enable;
    logic [15:0] instruction, PC_2;
    logic        if_valid, halted, err;

    fetch_unit #(.RESET_PC(16'h0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .stall(stall), .PCSrc(PCSrc),
        .PC_2_I(PC_2_I), .PC_2_D(PC_2_D), .reg_target(reg_target),
        .fetch_enable(fetch_enable),
        .instruction(instruction), .PC_2(PC_2), .if_valid(if_valid),
        .halted(halted), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] memfn(input logic [15:0] a);
        return {a[14:0], a[15]} ^ 16'h4001;
    endfunction

    // Model: PC, a captured-word flag, a squash flag and the IF/ID contents.
    logic [15:0] m_pc, m_hold, m_sq_tgt, m_instr, m_pc2;
    logic        m_have, m_sq, m_halt, m_valid, m_err;

    function automatic logic m_req();
        return !m_halt && !m_have;
    endfunction

    task automatic model_reset();
        m_pc = 16'h0000; m_hold = 16'h0000; m_sq_tgt = 16'h0000;
        m_instr = NOP; m_pc2 = 16'h0000;
        m_have = 1'b0; m_sq = 1'b0; m_halt = 1'b0; m_valid = 1'b0; m_err = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".req"},   {15'b0, imem_req}, 16'h0000);
        check({tag, ".addr"},  imem_addr, 16'h0000);
        check({tag, ".instr"}, instruction, NOP);
        check({tag, ".pc2"},   PC_2, 16'h0000);
        check({tag, ".valid"}, {15'b0, if_valid}, 16'h0000);
        check({tag, ".halted"},{15'b0, halted}, 16'h0000);
        check({tag, ".err"},   {15'b0, err}, 16'h0000);
    endtask

    task automatic compare_all();
        check("imem_req", {15'b0, imem_req}, {15'b0, m_req()});
        if (m_req())
            check("imem_addr", imem_addr, m_pc);
        check("instruction", instruction, m_instr);
        check("PC_2", PC_2, m_pc2);
        check("if_valid", {15'b0, if_valid}, {15'b0, m_valid});
        check("halted", {15'b0, halted}, {15'b0, m_halt});
        check("err", {15'b0, err}, {15'b0, m_err});
    endtask

    task automatic step_model(input logic rdy, input logic st, input logic [2:0] src,
                              input logic fe, input logic [15:0] ti,
                              input logic [15:0] td, input logic [15:0] tr);
        logic        req, done;
        logic [15:0] word, tgt;
        req  = m_req();
        done = req && rdy;
        if (m_halt) begin
            m_valid = 1'b0;
        end else if (m_valid && !fe) begin
            m_halt  = 1'b1;
            m_valid = 1'b0;
        end else begin
            if (m_valid && !st && src >= 3'd4)
                m_err = 1'b1;
            if (m_valid && !st && src != 3'd0 && src < 3'd4) begin
                tgt = (src == 3'd1) ? ti : (src == 3'd2) ? td : tr;
                m_valid = 1'b0;
                m_instr = NOP;
                m_have  = 1'b0;
                if (req && !done) begin
                    m_sq = 1'b1;
                    m_sq_tgt = tgt;
                end else begin
                    m_pc = tgt;
                end
            end else if (m_sq) begin
                if (!st) begin
                    m_valid = 1'b0;
                    m_instr = NOP;
                end
                if (done) begin
                    m_sq = 1'b0;
                    m_pc = m_sq_tgt;
                end
            end else begin
                word = m_have ? m_hold : memfn(m_pc);
                if (st) begin
                    if (done) begin
                        m_have = 1'b1;
                        m_hold = word;
                    end
                end else if (m_have || done) begin
                    m_instr = word;
                    m_pc    = m_pc + 16'd2;
                    m_pc2   = m_pc;
                    m_valid = 1'b1;
                    m_have  = 1'b0;
                end else begin
                    m_valid = 1'b0;
                    m_instr = NOP;
                end
            end
        end
    endtask

    function automatic logic [15:0] pick_target();
        case ($urandom_range(0, 2))
            0:       return 16'hFFFE;
            1:       return 16'h0040;
            default: return 16'($urandom_range(0, 32767) * 2);
        endcase
    endfunction

    task automatic drive_cycle(input int mode, input int cyc);
        logic rdy;
        logic st, fe;
        logic [2:0] src;
        logic [15:0] ti, td, tr;
        ti = pick_target(); td = pick_target(); tr = pick_target();
        st = 1'b0; src = 3'd0; fe = 1'b1;
        case (mode)
            0: rdy = m_req();
            1: begin
                rdy = m_req() && (cyc % 3 == 2);
                st  = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 9) == 0) src = 3'($urandom_range(1, 3));
            end
            default: begin
                rdy = m_req() && ($urandom_range(0, 1) == 1);
                st  = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 4) == 0) src = 3'($urandom_range(1, 7));
                fe  = ($urandom_range(0, 79) != 0);
            end
        endcase
        imem_ready   = rdy;
        imem_rdata   = rdy ? memfn(m_pc) : 16'($urandom);
        stall        = st;
        PCSrc        = src;
        fetch_enable = fe;
        PC_2_I       = ti;
        PC_2_D       = td;
        reg_target   = tr;
        step_model(rdy, st, src, fe, ti, td, tr);
    endtask

    initial begin
        imem_rdata = 16'h0000; imem_ready = 1'b0; stall = 1'b0; PCSrc = 3'd0;
        PC_2_I = 16'h0000; PC_2_D = 16'h0000; reg_target = 16'h0000;
        fetch_enable = 1'b1;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2 check_reset("init");
        model_reset();

        for (int ep = 0; ep < 12; ep++) begin
            @(negedge clk);
            if (ep > 0) begin
                compare_all();
                // Assert reset between edges to observe its asynchronous effect.
                #2 rst = 1'b0;
                #1 check_reset("async_rst");
                model_reset();
                imem_ready = 1'b0;
                @(negedge clk);
                check_reset("rst_held");
            end
            rst = 1'b1;
            for (int c = 0; c < 150; c++) begin
                if (c > 0) begin
                    @(negedge clk);
                    compare_all();
                end
                drive_cycle(ep % 3, c);
            end
        end
        @(negedge clk);
        compare_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
